// File: rtl/heap_ops_pkg.sv
// Shared heap operation encoding used by the heap banks and everything that
// consumes their responses.
package heap_ops;

  typedef enum logic [1:0] {
    HEAP_OP_ENQUE     = 2'd0,
    HEAP_OP_DEQUE_MIN = 2'd1,
    HEAP_OP_DEQUE_MAX = 2'd2,
    HEAP_OP_NOP       = 2'd3
  } heap_op_t;

endpackage

// File: rtl/bbq_resp_fifo.sv
// Small synchronous FIFO with count/full/empty; a pop frees room for a push in
// the same cycle, so push+pop at full keeps the count and ordering intact.
module bbq_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bbq_merger.sv
// Merges dequeue responses from two heap banks back into issue order, with
// flow control toward the router and a sticky protocol-error flag.
module bbq_merger
  import heap_ops::*;
#(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic                   issue_bank,
  input  logic                   in_0_valid,
  input  heap_op_t               in_0_op_type,
  input  logic [DWIDTH-1:0]      in_0_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_0_he_priority,
  input  logic                   in_1_valid,
  input  heap_op_t               in_1_op_type,
  input  logic [DWIDTH-1:0]      in_1_he_data,
  input  logic [PRIOR_WIDTH-1:0] in_1_he_priority,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_prior,
  output logic                   out_bank,
  output logic                   bbq_rdy,
  output logic                   err
);
  localparam int RW  = DWIDTH + PRIOR_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW = $clog2(ORDER_DEPTH) + 1;

  logic [1:0]     w_cap, w_res_push, w_res_pop, w_res_full, w_res_empty;
  logic [RW-1:0]  w_res_in    [2];
  logic [RW-1:0]  w_res_out   [2];
  logic [CW-1:0]  w_res_count [2];
  logic [CW-1:0]  r_outst     [2];
  logic [RW-1:0]  w_head;
  logic [OCW-1:0] w_ord_count;
  logic           w_ord_head, w_ord_full, w_ord_empty;
  logic           w_out_valid, w_pop, w_issue, w_rdy, w_err_set;
  logic           r_live, r_err;
  logic           w_unused;

  assign w_cap[0]    = in_0_valid && (in_0_op_type != HEAP_OP_ENQUE);
  assign w_cap[1]    = in_1_valid && (in_1_op_type != HEAP_OP_ENQUE);
  assign w_res_in[0] = {in_0_he_priority, in_0_he_data};
  assign w_res_in[1] = {in_1_he_priority, in_1_he_data};

  assign w_head      = w_ord_head ? w_res_out[1] : w_res_out[0];
  assign w_out_valid = !w_ord_empty && !(w_ord_head ? w_res_empty[1] : w_res_empty[0]);
  assign w_pop       = w_out_valid && out_ready;
  assign w_res_pop   = {w_pop && w_ord_head, w_pop && !w_ord_head};
  assign w_res_push  = w_cap & (~w_res_full | w_res_pop);

  // r_live holds bbq_rdy low through reset and for the edge that releases it.
  assign w_rdy   = r_live && (w_ord_count < OCW'(ORDER_DEPTH)) &&
                   (r_outst[0] < CW'(FIFO_DEPTH)) && (r_outst[1] < CW'(FIFO_DEPTH));
  assign w_issue = issue_valid && w_rdy;

  assign w_err_set = (issue_valid && !w_rdy) ||
                     (|(w_cap & w_res_full & ~w_res_pop)) ||
                     (w_cap[0] && (r_outst[0] == '0)) ||
                     (w_cap[1] && (r_outst[1] == '0));

  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_head[DWIDTH-1:0]  : '0;
  assign out_prior = w_out_valid ? w_head[RW-1:DWIDTH] : '0;
  assign out_bank  = w_out_valid ? w_ord_head          : 1'b0;
  assign bbq_rdy   = w_rdy;
  assign err       = r_err;
  assign w_unused  = ^{w_res_count[0], w_res_count[1], w_ord_full};

  for (genvar g = 0; g < 2; g++) begin : g_res
    bbq_resp_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_res (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_res_push[g]),
      .i_data  (w_res_in[g]),
      .i_pop   (w_res_pop[g]),
      .o_data  (w_res_out[g]),
      .o_count (w_res_count[g]),
      .o_full  (w_res_full[g]),
      .o_empty (w_res_empty[g])
    );
  end

  bbq_resp_fifo #(.WIDTH(1), .DEPTH(ORDER_DEPTH)) u_order (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_data  (issue_bank),
    .i_pop   (w_pop),
    .o_data  (w_ord_head),
    .o_count (w_ord_count),
    .o_full  (w_ord_full),
    .o_empty (w_ord_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst[0] <= '0;
      r_outst[1] <= '0;
      r_live     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_err_set) r_err <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        case ({w_issue && (issue_bank == n[0]), w_res_pop[n]})
          2'b10:   r_outst[n] <= r_outst[n] + CW'(1);
          2'b01:   r_outst[n] <= r_outst[n] - CW'(1);
          default: r_outst[n] <= r_outst[n];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bbq_merger.sv
// Self-checking bench for bbq_merger: directed scenarios plus random traffic
// compared against a queue-based model of in-order merging.
module tb_bbq_merger;
  import heap_ops::*;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam int FD = 4;
  localparam int OD = 8;
  localparam int RW = DW + PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0, issue_bank = 1'b0;
  logic          in_0_valid = 1'b0, in_1_valid = 1'b0;
  heap_op_t      in_0_op_type = HEAP_OP_NOP, in_1_op_type = HEAP_OP_NOP;
  logic [DW-1:0] in_0_he_data = '0, in_1_he_data = '0;
  logic [PW-1:0] in_0_he_priority = '0, in_1_he_priority = '0;
  logic          out_valid, out_ready = 1'b0, out_bank, bbq_rdy, err;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_prior;

  int nvec = 0;
  int nerr = 0;

  bbq_merger #(.DWIDTH(DW), .PRIOR_WIDTH(PW), .FIFO_DEPTH(FD), .ORDER_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_bank(issue_bank),
    .in_0_valid(in_0_valid), .in_0_op_type(in_0_op_type), .in_0_he_data(in_0_he_data),
    .in_0_he_priority(in_0_he_priority),
    .in_1_valid(in_1_valid), .in_1_op_type(in_1_op_type), .in_1_he_data(in_1_he_data),
    .in_1_he_priority(in_1_he_priority),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_prior(out_prior), .out_bank(out_bank), .bbq_rdy(bbq_rdy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: issue order, per-bank result queues, outstanding issues.
  bit            oq[$];
  logic [RW-1:0] rq0[$];
  logic [RW-1:0] rq1[$];
  int            m_out[2];
  bit            m_err, m_live;
  int            pend[2];

  function automatic bit e_valid();
    if (oq.size() == 0) return 1'b0;
    return (oq[0] == 1'b0) ? (rq0.size() > 0) : (rq1.size() > 0);
  endfunction

  function automatic logic [RW-1:0] e_head();
    if (!e_valid()) return '0;
    return (oq[0] == 1'b0) ? rq0[0] : rq1[0];
  endfunction

  function automatic bit e_bank();
    return e_valid() ? oq[0] : 1'b0;
  endfunction

  function automatic bit m_rdy();
    return m_live && (oq.size() < OD) && (m_out[0] < FD) && (m_out[1] < FD);
  endfunction

  task automatic m_clear();
    oq.delete(); rq0.delete(); rq1.delete();
    m_out[0] = 0; m_out[1] = 0; pend[0] = 0; pend[1] = 0;
    m_err = 1'b0; m_live = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, pop, h, cap0, cap1, room0, room1;
    rdy  = m_rdy();
    pop  = e_valid() && out_ready;
    h    = e_bank();
    cap0 = in_0_valid && (in_0_op_type != HEAP_OP_ENQUE);
    cap1 = in_1_valid && (in_1_op_type != HEAP_OP_ENQUE);
    room0 = (rq0.size() < FD) || (pop && h == 1'b0);
    room1 = (rq1.size() < FD) || (pop && h == 1'b1);
    if (issue_valid && !rdy) m_err = 1'b1;
    if (cap0 && (m_out[0] == 0 || !room0)) m_err = 1'b1;
    if (cap1 && (m_out[1] == 0 || !room1)) m_err = 1'b1;
    if (pop) begin
      void'(oq.pop_front());
      if (h == 1'b0) void'(rq0.pop_front()); else void'(rq1.pop_front());
      m_out[h] = m_out[h] - 1;
    end
    if (cap0 && room0) rq0.push_back({in_0_he_priority, in_0_he_data});
    if (cap1 && room1) rq1.push_back({in_1_he_priority, in_1_he_data});
    if (issue_valid && rdy) begin
      oq.push_back(issue_bank);
      m_out[issue_bank] = m_out[issue_bank] + 1;
    end
    m_live = 1'b1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; in_0_valid = 1'b0; in_1_valid = 1'b0;
  endtask

  task automatic resp(input bit b, input heap_op_t op, input logic [DW-1:0] d, input logic [PW-1:0] p);
    if (b == 1'b0) begin
      in_0_valid = 1'b1; in_0_op_type = op; in_0_he_data = d; in_0_he_priority = p;
    end else begin
      in_1_valid = 1'b1; in_1_op_type = op; in_1_he_data = d; in_1_he_priority = p;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); out_ready = 1'b0; rst = 1'b1; m_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    idle(); m_clear();
    repeat (2) @(posedge clk);
    #1;
    if (out_valid !== 1'b0) begin $display("FAIL rst_valid got %b exp 0", out_valid); nerr++; end
    nvec++;
    if (bbq_rdy !== 1'b0) begin $display("FAIL rst_rdy got %b exp 0", bbq_rdy); nerr++; end
    nvec++;
    if ({err, out_data, out_prior, out_bank} !== '0) begin
      $display("FAIL rst_payload got err=%b d=%h p=%h b=%b exp 0", err, out_data, out_prior, out_bank); nerr++;
    end
    nvec++;
    rst = 1'b0;
    #1;
    if (bbq_rdy !== 1'b0) begin $display("FAIL rst_release_rdy got %b exp 0", bbq_rdy); nerr++; end
    nvec++;
    cycle();
    if (bbq_rdy !== 1'b1) begin $display("FAIL rst_rise_rdy got %b exp 1", bbq_rdy); nerr++; end
    nvec++;
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1'b1; issue_bank = 1'b0;
    cycle();
    idle(); out_ready = 1'b1;
    resp(1'b0, HEAP_OP_DEQUE_MIN, 32'h0000_00A5, 6'd3);
    cycle();
    idle();
    if ({out_valid, out_data, out_prior, out_bank} !== {1'b1, 32'h0000_00A5, 6'd3, 1'b0}) begin
      $display("FAIL single_out got v=%b d=%h p=%0d b=%b exp v=1 d=a5 p=3 b=0", out_valid, out_data, out_prior, out_bank); nerr++;
    end
    nvec++;
    cycle();
    if (out_valid !== 1'b0) begin $display("FAIL single_pop got %b exp 0", out_valid); nerr++; end
    nvec++;
  endtask

  task automatic test_order();
    do_reset();
    out_ready = 1'b1;
    issue_valid = 1'b1; issue_bank = 1'b1; cycle();
    issue_bank = 1'b0; cycle();
    idle(); resp(1'b0, HEAP_OP_DEQUE_MIN, 32'h11, 6'd1); cycle();
    idle(); cycle();
    if (out_valid !== 1'b0) begin $display("FAIL order_wait got %b exp 0", out_valid); nerr++; end
    nvec++;
    resp(1'b1, HEAP_OP_DEQUE_MAX, 32'h22, 6'd2); cycle();
    idle();
    if ({out_valid, out_data, out_bank} !== {1'b1, 32'h22, 1'b1}) begin
      $display("FAIL order_first got v=%b d=%h b=%b exp v=1 d=22 b=1", out_valid, out_data, out_bank); nerr++;
    end
    nvec++;
    cycle();
    if ({out_valid, out_data, out_bank} !== {1'b1, 32'h11, 1'b0}) begin
      $display("FAIL order_second got v=%b d=%h b=%b exp v=1 d=11 b=0", out_valid, out_data, out_bank); nerr++;
    end
    nvec++;
    cycle();
  endtask

  task automatic test_issue_full();
    int popped;
    do_reset();
    issue_valid = 1'b1; issue_bank = 1'b0;
    repeat (4) cycle();
    if (bbq_rdy !== 1'b0) begin $display("FAIL full_rdy got %b exp 0", bbq_rdy); nerr++; end
    nvec++;
    cycle();
    idle();
    if (err !== 1'b1) begin $display("FAIL full_err got %b exp 1", err); nerr++; end
    nvec++;
    for (int i = 0; i < 4; i++) begin resp(1'b0, HEAP_OP_DEQUE_MIN, DW'(i), 6'd0); cycle(); end
    idle(); out_ready = 1'b1; popped = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) popped++;
      cycle();
    end
    if (popped != 4) begin $display("FAIL full_count got %0d exp 4", popped); nerr++; end
    nvec++;
  endtask

  task automatic test_enque();
    do_reset();
    issue_valid = 1'b1; issue_bank = 1'b0; cycle();
    idle(); resp(1'b0, HEAP_OP_ENQUE, 32'hDEAD, 6'd9); cycle();
    idle(); cycle();
    if ({out_valid, err} !== 2'b00) begin $display("FAIL enque_ignored got v=%b err=%b exp 00", out_valid, err); nerr++; end
    nvec++;
    resp(1'b1, HEAP_OP_DEQUE_MIN, 32'h5, 6'd5); cycle();
    idle();
    if (err !== 1'b1) begin $display("FAIL unsolicited_err got %b exp 1", err); nerr++; end
    nvec++;
  endtask

  task automatic test_back_to_back();
    int issued, popped, nxt, cyc;
    do_reset();
    out_ready = 1'b1; issued = 0; popped = 0; nxt = 0; cyc = 0;
    while (popped < 20 && cyc < 200) begin
      idle();
      if (out_valid === 1'b1) begin
        if (out_data !== DW'(32'h100 + popped)) begin
          $display("FAIL wrap_data got %h exp %h", out_data, 32'h100 + popped); nerr++;
        end
        nvec++;
        popped++;
      end
      if (pend[0] > 0) begin resp(1'b0, HEAP_OP_DEQUE_MIN, DW'(32'h100 + nxt), 6'd7); nxt++; pend[0]--; end
      if (issued < 20 && m_rdy()) begin issue_valid = 1'b1; issue_bank = 1'b0; issued++; pend[0]++; end
      cycle(); cyc++;
    end
    if (popped != 20 || err !== 1'b0) begin $display("FAIL wrap_done got popped=%0d err=%b exp 20 0", popped, err); nerr++; end
    nvec++;
    // Result FIFO full, pop and new capture in the same cycle.
    do_reset();
    issue_valid = 1'b1; issue_bank = 1'b0;
    repeat (4) cycle();
    idle();
    for (int i = 0; i < 4; i++) begin resp(1'b0, HEAP_OP_DEQUE_MIN, DW'(32'h200 + i), 6'd1); cycle(); end
    out_ready = 1'b1; resp(1'b0, HEAP_OP_DEQUE_MIN, 32'h204, 6'd1); cycle();
    idle();
    for (int i = 1; i < 4; i++) begin
      if ({out_valid, out_data, err} !== {1'b1, DW'(32'h200 + i), 1'b0}) begin
        $display("FAIL fullpp_data got v=%b d=%h err=%b exp v=1 d=%h err=0", out_valid, out_data, err, 32'h200 + i); nerr++;
      end
      nvec++;
      cycle();
    end
    issue_valid = 1'b1; issue_bank = 1'b0; cycle();
    idle();
    if ({out_valid, out_data} !== {1'b1, 32'h204}) begin
      $display("FAIL fullpp_kept got v=%b d=%h exp v=1 d=204", out_valid, out_data); nerr++;
    end
    nvec++;
  endtask

  task automatic test_random();
    bit acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (out_valid !== e_valid()) begin $display("FAIL rand_valid cyc %0d got %b exp %b", c, out_valid, e_valid()); nerr++; end
      nvec++;
      if ({out_prior, out_data, out_bank} !== {e_head(), e_bank()}) begin
        $display("FAIL rand_payload cyc %0d got %h exp %h", c, {out_prior, out_data, out_bank}, {e_head(), e_bank()}); nerr++;
      end
      nvec++;
      if ({bbq_rdy, err} !== {m_rdy(), m_err}) begin
        $display("FAIL rand_flags cyc %0d got rdy=%b err=%b exp rdy=%b err=%b", c, bbq_rdy, err, m_rdy(), m_err); nerr++;
      end
      nvec++;
      idle();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        issue_bank  = 1'($urandom_range(0, 1));
        issue_valid = m_rdy() || ($urandom_range(0, 40) == 0);
      end
      acc = issue_valid && m_rdy();
      for (int b = 0; b < 2; b++) begin
        if (pend[b] > 0 && $urandom_range(0, 2) == 0) begin
          resp(1'(b), heap_op_t'($urandom_range(1, 3)), DW'($urandom), PW'($urandom)); pend[b]--;
        end else if ($urandom_range(0, 9) == 0) begin
          resp(1'(b), HEAP_OP_ENQUE, DW'($urandom), PW'($urandom));
        end
      end
      if (acc) pend[issue_bank]++;
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_valid = 1'b1; issue_bank = 1'b0;
    repeat (3) cycle();
    issue_valid = 1'b1; issue_bank = 1'b1; cycle();
    idle();
    for (int i = 0; i < 3; i++) begin resp(1'b0, HEAP_OP_DEQUE_MIN, DW'(i + 1), 6'd2); cycle(); end
    idle(); cycle();
    if (out_valid !== 1'b1) begin $display("FAIL mid_buffered got %b exp 1", out_valid); nerr++; end
    nvec++;
    issue_valid = 1'b1; issue_bank = 1'b0; cycle();
    idle();
    #2 rst = 1'b1; m_clear();
    #1;
    if ({out_valid, err, bbq_rdy} !== 3'b000) begin
      $display("FAIL mid_reset got v=%b err=%b rdy=%b exp 000", out_valid, err, bbq_rdy); nerr++;
    end
    nvec++;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    if ({bbq_rdy, out_valid} !== 2'b10) begin
      $display("FAIL mid_release got rdy=%b v=%b exp rdy=1 v=0", bbq_rdy, out_valid); nerr++;
    end
    nvec++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_issue_full();
    test_enque();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/bbq_merger.md
BBQ_MERGER -- requirements
Module: bbq_merger

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, heap element data width.
REQ-002 SHALL have parameter PRIOR_WIDTH, default 6, heap element priority width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, per-bank result FIFO depth; power of 2, at least 2.
REQ-004 SHALL have parameter ORDER_DEPTH, default 8, issue-order FIFO depth; power of 2, at least 2.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port issue_valid  input  1  a dequeue was issued to a heap bank this cycle.
REQ-008 SHALL have port issue_bank  input  1  index (0/1) of the bank that received that dequeue.
REQ-009 SHALL have ports in_0_valid  input  1, in_0_op_type  input  heap_op_t, in_0_he_data  input  DWIDTH, in_0_he_priority  input  PRIOR_WIDTH; these carry bank 0 heap responses.
REQ-010 SHALL have ports in_1_valid, in_1_op_type, in_1_he_data, in_1_he_priority, identical to REQ-009, carrying bank 1 heap responses.
REQ-011 SHALL have port out_valid  output  1  merged result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have ports out_data  output  DWIDTH, out_prior  output  PRIOR_WIDTH, out_bank  output  1; these carry the merged result payload and its source bank.
REQ-014 SHALL have port bbq_rdy  output  1  upstream router may issue a dequeue this cycle.
REQ-015 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-016 A response SHALL be captured only when in_N_valid=1 and in_N_op_type is not HEAP_OP_ENQUE; enqueue acknowledgements are discarded.
REQ-017 A captured response SHALL be written into result FIFO N at the clock edge, and SHALL become visible on out_* no earlier than the next cycle.
REQ-018 Each cycle with issue_valid=1 and bbq_rdy=1 SHALL push issue_bank into the order FIFO and increment outstanding counter N.
REQ-019 out_valid SHALL be 1 only when the order FIFO is non-empty and the result FIFO selected by its head is non-empty.
REQ-020 When out_valid=1, out_data, out_prior and out_bank SHALL equal the head of that result FIFO and the order-FIFO head.
REQ-021 out_valid and out_ready both 1 SHALL pop the order FIFO and the selected result FIFO, and SHALL decrement that bank's outstanding counter.
REQ-022 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Results SHALL be emitted strictly in issue order; a ready result on the other bank SHALL wait behind a pending head.
REQ-024 bbq_rdy SHALL be 1 iff order count < ORDER_DEPTH and both outstanding counters < FIFO_DEPTH; it SHALL be derived combinationally from registers only.
REQ-025 A push and a pop on the same FIFO or counter in the same cycle SHALL leave its count unchanged and preserve data order, including at full and at empty.
REQ-026 Simultaneous captures on both banks SHALL both be stored.
REQ-027 FIFO pointers SHALL wrap modulo their depth with no lost or duplicated entries.
REQ-028 err SHALL set and hold until reset on any of: issue_valid=1 with bbq_rdy=0 (the issue is ignored); a capture into a full result FIFO (the response is dropped); a capture on a bank whose outstanding count is 0.

Reset
REQ-029 rst=1 SHALL asynchronously clear all FIFO pointers, counts and outstanding counters, and SHALL clear err.
REQ-030 During reset, out_valid SHALL be 0 and bbq_rdy SHALL be 0; out_data, out_prior and out_bank SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard all buffered and in-flight entries.
REQ-032 bbq_rdy SHALL rise in the first cycle after rst deasserts.

Structure
REQ-033 heap_op_t and HEAP_OP_ENQUE SHALL come from the shared heap_ops package; no new typedefs SHALL be added locally.
REQ-034 One parameterized sub-module, bbq_resp_fifo (width and depth, with count/full/empty outputs), SHALL implement both result FIFOs and the order FIFO.

Verification
REQ-035 Issue bank 0; next cycle bank 0 responds with data 0xA5, priority 3; out_ready=1 -> out_valid the following cycle with out_data=0xA5, out_prior=3, out_bank=0, popped in one cycle.
REQ-036 Issue bank 1 then bank 0; bank 0 responds first (0x11), bank 1 responds later (0x22) -> output order is 0x22 then 0x11.
REQ-037 Hold out_ready=0 and issue 4 dequeues to bank 0 -> bbq_rdy=0 after the 4th; a 5th issue sets err and is ignored; count stays 4.
REQ-038 In_0 delivers HEAP_OP_ENQUE with valid=1 -> nothing captured; err stays 0.
REQ-039 Bank 0 result FIFO full with out_ready=1 and a new response in the same cycle -> no drop, count unchanged, order preserved; run 20 entries for wrap-around.
REQ-040 Assert rst with 3 entries buffered -> out_valid=0 immediately, err=0, bbq_rdy=1 one cycle after release.
